// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, 50 MHz
// default cycle constants and the counter-width helper.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    STABLE      = 3'd1,
    SYS_HOLD    = 3'd2,
    SDRAM_PWRUP = 3'd3,
    RUN         = 3'd4
  } seq_state_e;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_SYS_RST_HOLD_CYCLES = 16;
  localparam int DEF_SDRAM_PWRUP_CYCLES  = 10000;  // 200 us at 50 MHz

  // Width of the shared up-counter: it must hold (largest cycle count - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the SoC it controls.
interface pll_reset_sequencer_if;

  // No valid/ready handshake: pll_locked is a level, asynchronous to clk;
  // sw_rst_req is a one-cycle pulse, acted on only when the sequencer is in
  // RUN and lock is still present; all other signals are registered levels.
  logic       pll_locked;
  logic       sw_rst_req;
  logic       sys_rst_n;
  logic       sdram_rst_n;
  logic       sdram_pwrup_done;
  logic       lost_lock;
  logic [7:0] lock_loss_count;
  logic [2:0] state_o;

  modport master (
    output pll_locked, sw_rst_req,
    input  sys_rst_n, sdram_rst_n, sdram_pwrup_done, lost_lock,
           lock_loss_count, state_o
  );

  modport slave (
    input  pll_locked, sw_rst_req,
    output sys_rst_n, sdram_rst_n, sdram_pwrup_done, lost_lock,
           lock_loss_count, state_o
  );

endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// N-flop synchronizer for the asynchronous PLL lock, with synchronous
// active-low clear.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!resetn) chain <= '0;
    else         chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, then releases the system reset and, after the SDRAM
// power-up interval, the SDRAM controller reset. Lock loss restarts it all.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int SYS_RST_HOLD_CYCLES = DEF_SYS_RST_HOLD_CYCLES,
  parameter int SDRAM_PWRUP_CYCLES  = DEF_SDRAM_PWRUP_CYCLES
) (
  input  logic                   clk,
  input  logic                   resetn,
  pll_reset_sequencer_if.slave   bus
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, SYS_RST_HOLD_CYCLES,
                                   SDRAM_PWRUP_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SYS_RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(SDRAM_PWRUP_CYCLES - 1);

  logic             lock_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loss_event;
  logic             run_loss;

  lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (bus.pll_locked),
    .q      (lock_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    loss_event = 1'b0;
    run_loss   = 1'b0;
    // Any loss of lock outside WAIT_LOCK wins over every other condition.
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d    = WAIT_LOCK;
      loss_event = 1'b1;
      run_loss   = (state_q == RUN);
    end else begin
      case (state_q)
        WAIT_LOCK:   if (lock_s)             state_d = STABLE;
        STABLE:      if (cnt_q == LOCK_LAST)  state_d = SYS_HOLD;
        SYS_HOLD:    if (cnt_q == HOLD_LAST)  state_d = SDRAM_PWRUP;
        SDRAM_PWRUP: if (cnt_q == PWRUP_LAST) state_d = RUN;
        RUN:         if (bus.sw_rst_req)      state_d = SYS_HOLD;
        default:                              state_d = WAIT_LOCK;
      endcase
    end
    if (state_d != state_q || state_q == WAIT_LOCK || state_q == RUN)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q              <= WAIT_LOCK;
      cnt_q                <= '0;
      bus.sys_rst_n        <= 1'b0;
      bus.sdram_rst_n      <= 1'b0;
      bus.sdram_pwrup_done <= 1'b0;
      bus.lost_lock        <= 1'b0;
      bus.lock_loss_count  <= 8'd0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      // Outputs decode the state being entered so they change with it.
      bus.sys_rst_n        <= (state_d == SDRAM_PWRUP) || (state_d == RUN);
      bus.sdram_rst_n      <= (state_d == RUN);
      bus.sdram_pwrup_done <= (state_d == RUN);
      if (run_loss) bus.lost_lock <= 1'b1;
      if (loss_event && bus.lock_loss_count != 8'hFF)
        bus.lock_loss_count <= bus.lock_loss_count + 8'd1;
    end
  end

  assign bus.state_o = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters
// (sync 2, stable 4, hold 3, power-up 5).
module tb_pll_reset_sequencer;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES         (2),
    .LOCK_STABLE_CYCLES  (4),
    .SYS_RST_HOLD_CYCLES (3),
    .SDRAM_PWRUP_CYCLES  (5)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are observed 1 time unit after the edge
  // and inputs changed there are first sampled by the following edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected state on a clean lock-up, after edge e (edge 1 = first edge
  // sampling pll_locked=1 with the synchronizer empty).
  function automatic logic [2:0] exp_state(input int e);
    if (e <= 2)       return 3'd0;
    else if (e <= 6)  return 3'd1;
    else if (e <= 9)  return 3'd2;
    else if (e <= 14) return 3'd3;
    else              return 3'd4;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    tick(2);
    n_vec++;
    if (bus.state_o !== 3'd0 || bus.sys_rst_n !== 1'b0 || bus.sdram_rst_n !== 1'b0 ||
        bus.sdram_pwrup_done !== 1'b0 || bus.lost_lock !== 1'b0 ||
        bus.lock_loss_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset: state=%0d sys=%b sdram=%b done=%b lost=%b cnt=%0d, want all 0",
               bus.state_o, bus.sys_rst_n, bus.sdram_rst_n, bus.sdram_pwrup_done,
               bus.lost_lock, bus.lock_loss_count);
    end
    resetn = 1'b1;
    tick(3);
    n_vec++;
    if (bus.state_o !== 3'd0 || bus.sys_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_lock: state=%0d sys=%b, want 0 0", bus.state_o, bus.sys_rst_n);
    end
  endtask

  task automatic test_clean_powerup();
    bus.pll_locked = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      n_vec++;
      if (bus.state_o !== exp_state(e) || bus.sys_rst_n !== (e >= 10) ||
          bus.sdram_rst_n !== (e >= 15) || bus.sdram_pwrup_done !== (e >= 15)) begin
        n_err++;
        $display("FAIL powerup e%0d: state=%0d sys=%b sdram=%b done=%b, want %0d %b %b %b",
                 e, bus.state_o, bus.sys_rst_n, bus.sdram_rst_n, bus.sdram_pwrup_done,
                 exp_state(e), e >= 10, e >= 15, e >= 15);
      end
    end
    n_vec++;
    if (bus.lock_loss_count !== 8'd0 || bus.lost_lock !== 1'b0) begin
      n_err++;
      $display("FAIL powerup_cnt: cnt=%0d lost=%b, want 0 0", bus.lock_loss_count, bus.lost_lock);
    end
  endtask

  task automatic test_glitchy_lock();
    test_reset();
    bus.pll_locked = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      if (e == 5) bus.pll_locked = 1'b0;
      tick(1);
      n_vec++;
      if (bus.sys_rst_n !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_sys e%0d: sys=%b, want 0", e, bus.sys_rst_n);
      end
    end
    n_vec++;
    if (bus.state_o !== 3'd0 || bus.lock_loss_count !== 8'd1 || bus.lost_lock !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_drop: state=%0d cnt=%0d lost=%b, want 0 1 0",
               bus.state_o, bus.lock_loss_count, bus.lost_lock);
    end
    bus.pll_locked = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick(1);
      n_vec++;
      if (bus.state_o !== exp_state(e) || bus.sys_rst_n !== (e >= 10)) begin
        n_err++;
        $display("FAIL glitch_relock e%0d: state=%0d sys=%b, want %0d %b",
                 e, bus.state_o, bus.sys_rst_n, exp_state(e), e >= 10);
      end
    end
  endtask

  task automatic test_lock_loss_run();
    bus.pll_locked = 1'b0;
    tick(2);
    n_vec++;
    if (bus.state_o !== 3'd4 || bus.sdram_rst_n !== 1'b1) begin
      n_err++;
      $display("FAIL loss_pending: state=%0d sdram=%b, want 4 1", bus.state_o, bus.sdram_rst_n);
    end
    tick(1);
    n_vec++;
    if (bus.state_o !== 3'd0 || bus.sys_rst_n !== 1'b0 || bus.sdram_rst_n !== 1'b0 ||
        bus.sdram_pwrup_done !== 1'b0 || bus.lost_lock !== 1'b1 ||
        bus.lock_loss_count !== 8'd2) begin
      n_err++;
      $display("FAIL loss_run: state=%0d sys=%b sdram=%b done=%b lost=%b cnt=%0d, want 0 0 0 0 1 2",
               bus.state_o, bus.sys_rst_n, bus.sdram_rst_n, bus.sdram_pwrup_done,
               bus.lost_lock, bus.lock_loss_count);
    end
    bus.pll_locked = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick(1);
      n_vec++;
      if (bus.state_o !== exp_state(e) || bus.sdram_rst_n !== (e >= 15) ||
          bus.lost_lock !== 1'b1) begin
        n_err++;
        $display("FAIL loss_relock e%0d: state=%0d sdram=%b lost=%b, want %0d %b 1",
                 e, bus.state_o, bus.sdram_rst_n, bus.lost_lock, exp_state(e), e >= 15);
      end
    end
  endtask

  task automatic test_warm_reset();
    logic [2:0] ws;
    bus.sw_rst_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      bus.sw_rst_req = 1'b0;
      ws = (k <= 3) ? 3'd2 : (k <= 8) ? 3'd3 : 3'd4;
      n_vec++;
      if (bus.state_o !== ws || bus.sys_rst_n !== (k >= 4) || bus.sdram_rst_n !== (k >= 9) ||
          bus.lost_lock !== 1'b1 || bus.lock_loss_count !== 8'd2) begin
        n_err++;
        $display("FAIL warm k%0d: state=%0d sys=%b sdram=%b lost=%b cnt=%0d, want %0d %b %b 1 2",
                 k, bus.state_o, bus.sys_rst_n, bus.sdram_rst_n, bus.lost_lock,
                 bus.lock_loss_count, ws, k >= 4, k >= 9);
      end
    end
    // Drop lock, then requalify with a warm-reset pulse landing in STABLE.
    bus.pll_locked = 1'b0;
    tick(3);
    bus.pll_locked = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      bus.sw_rst_req = (e == 5);
      tick(1);
      n_vec++;
      if (bus.state_o !== exp_state(e) || bus.sys_rst_n !== (e >= 10)) begin
        n_err++;
        $display("FAIL warm_stable e%0d: state=%0d sys=%b, want %0d %b",
                 e, bus.state_o, bus.sys_rst_n, exp_state(e), e >= 10);
      end
    end
    bus.sw_rst_req = 1'b0;
    n_vec++;
    if (bus.lock_loss_count !== 8'd3) begin
      n_err++;
      $display("FAIL warm_cnt: cnt=%0d, want 3", bus.lock_loss_count);
    end
  endtask

  task automatic test_priority_saturation();
    bus.pll_locked = 1'b0;
    tick(2);
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    n_vec++;
    if (bus.state_o !== 3'd0 || bus.sys_rst_n !== 1'b0 || bus.lock_loss_count !== 8'd4) begin
      n_err++;
      $display("FAIL priority: state=%0d sys=%b cnt=%0d, want 0 0 4",
               bus.state_o, bus.sys_rst_n, bus.lock_loss_count);
    end
    // Each 6-edge period reaches STABLE and drops out before qualifying.
    for (int i = 1; i <= 300; i++) begin
      bus.pll_locked = 1'b1;
      tick(3);
      bus.pll_locked = 1'b0;
      tick(3);
      if (i == 250) begin
        n_vec++;
        if (bus.lock_loss_count !== 8'd254) begin
          n_err++;
          $display("FAIL sat_254: cnt=%0d, want 254", bus.lock_loss_count);
        end
      end
    end
    n_vec++;
    if (bus.lock_loss_count !== 8'd255 || bus.state_o !== 3'd0 || bus.sys_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL sat_255: cnt=%0d state=%0d sys=%b, want 255 0 0",
               bus.lock_loss_count, bus.state_o, bus.sys_rst_n);
    end
  endtask

  task automatic test_mid_reset();
    bus.pll_locked = 1'b1;
    tick(12);
    n_vec++;
    if (bus.state_o !== 3'd3 || bus.sys_rst_n !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: state=%0d sys=%b, want 3 1", bus.state_o, bus.sys_rst_n);
    end
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    n_vec++;
    if (bus.state_o !== 3'd0 || bus.sys_rst_n !== 1'b0 || bus.sdram_rst_n !== 1'b0 ||
        bus.sdram_pwrup_done !== 1'b0 || bus.lost_lock !== 1'b0 ||
        bus.lock_loss_count !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset: state=%0d sys=%b sdram=%b done=%b lost=%b cnt=%0d, want all 0",
               bus.state_o, bus.sys_rst_n, bus.sdram_rst_n, bus.sdram_pwrup_done,
               bus.lost_lock, bus.lock_loss_count);
    end
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      n_vec++;
      if (bus.state_o !== exp_state(e) || bus.sys_rst_n !== (e >= 10) ||
          bus.sdram_rst_n !== (e >= 15) || bus.lock_loss_count !== 8'd0) begin
        n_err++;
        $display("FAIL mid_resume e%0d: state=%0d sys=%b sdram=%b cnt=%0d, want %0d %b %b 0",
                 e, bus.state_o, bus.sys_rst_n, bus.sdram_rst_n, bus.lock_loss_count,
                 exp_state(e), e >= 10, e >= 15);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0;
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    test_reset();
    test_clean_powerup();
    test_glitchy_lock();
    test_lock_loss_run();
    test_warm_reset();
    test_priority_saturation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
